chol_inv_sqrt_nr: RTL

Parametrised fixed-point reciprocal square root engine for the Cholesky datapath. It computes 1/sqrt(x) of an unsigned Q(WIDTH-FRAC).FRAC operand using three steps: even-shift normalisation, a LUT seed, and ITER Newton-Raphson refinements on one shared internal pipelined multiplier. It needs no vendor IP and uses valid/ready handshakes on both sides. It sits between the diagonal-element accumulator and the column-scaling stage.

---
 rtl/chol_inv_sqrt_nr.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/chol_inv_sqrt_nr.sv
// chol_inv_sqrt_nr: fixed-point 1/sqrt(x) built from even-shift normalisation, a LUT seed and Newton-Raphson steps.
module chol_inv_sqrt_nr #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int ITER     = 2,
  parameter int MUL_LAT  = 2,
  parameter int LUT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);
  localparam int HW = $clog2(WIDTH / 2);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam int IW = $clog2(ITER + 1);
  localparam int SB = 2 + 3 * (FRAC / 2) - 3 * (WIDTH / 2);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3) << (WIDTH - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_NORM, S_SEED, S_SQ, S_MXY, S_NR, S_MUL, S_SCALE, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, y_q, y_d, t_q, t_d, od_q, od_d;
  logic [HW-1:0] h_q, h_d, hn;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] it_q, it_d;
  logic oe_q, oe_d, last, sat;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [2*WIDTH-1:0] prod, mul_out, wide;
  logic signed [7:0] sh;
  logic [6:0] lsh, rsh;
  logic [WIDTH-1:0] lut [2**LUT_BITS];

  // Seeds approximate 1/sqrt of each bin midpoint; the lowest quarter of bins cannot occur after normalisation.
  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_lut
    localparam real MID = (real'(g) + 0.5) / real'(2**LUT_BITS);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(longint'(2.0**(WIDTH-2) / $sqrt(MID)));
    assign lut[g] = (g < 2**(LUT_BITS-2)) ? '0 : SEED;
  end

  assign op_a = (state_q == S_MXY) ? m_q >> 2 : y_q;
  assign op_b = (state_q == S_SQ) ? y_q : t_q;
  assign prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // The destination register (t_q or y_q) is the final multiplier stage.
  if (MUL_LAT == 1) begin : g_m1
    assign mul_out = prod;
  end else begin : g_mp
    logic [MUL_LAT-2:0][2*WIDTH-1:0] pp_q;
    always_ff @(posedge clk) begin
      if (clken) begin
        pp_q[0] <= prod;
        for (int i = 1; i < MUL_LAT - 1; i++) pp_q[i] <= pp_q[i-1];
      end
    end
    assign mul_out = pp_q[MUL_LAT-2];
  end

  assign res  = WIDTH'(mul_out >> (WIDTH - 2));
  assign last = cnt_q == CW'(MUL_LAT - 1);

  always_comb begin
    hn = '0;
    for (int i = 0; i < WIDTH / 2; i++) if (m_q[2*i +: 2] != 2'b00) hn = HW'(WIDTH / 2 - 1 - i);
  end

  always_comb begin
    sh   = 8'(SB + int'(h_q));
    lsh  = (sh > 0) ? 7'(sh) : '0;
    rsh  = (sh < 0) ? 7'(-sh) : '0;
    wide = ({{WIDTH{1'b0}}, y_q} << lsh) >> rsh;
    sat  = |wide[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    h_d     = h_q;
    y_d     = y_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    it_d    = it_q;
    od_d    = od_q;
    oe_d    = oe_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        m_d     = in_data;
        state_d = S_NORM;
      end
      S_NORM: if (m_q == '0) begin
        od_d    = '1;
        oe_d    = 1'b1;
        state_d = S_DONE;
      end else begin
        m_d     = m_q << {hn, 1'b0};
        h_d     = hn;
        state_d = S_SEED;
      end
      S_SEED: begin
        y_d     = lut[m_q[WIDTH-1 -: LUT_BITS]];
        cnt_d   = '0;
        it_d    = '0;
        state_d = S_SQ;
      end
      S_SQ: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          t_d     = res;
          state_d = S_MXY;
        end
      end
      S_MXY: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          t_d     = res;
          state_d = S_NR;
        end
      end
      S_NR: begin
        t_d     = (THREE - t_q) >> 1;
        state_d = S_MUL;
      end
      S_MUL: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          y_d     = res;
          it_d    = it_q + 1'b1;
          state_d = (it_q == IW'(ITER - 1)) ? S_SCALE : S_SQ;
        end
      end
      S_SCALE: begin
        od_d    = sat ? '1 : wide[WIDTH-1:0];
        oe_d    = sat;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      h_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      it_q    <= '0;
      od_q    <= '0;
      oe_q    <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      m_q     <= m_d;
      h_q     <= h_d;
      y_q     <= y_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      it_q    <= it_d;
      od_q    <= od_d;
      oe_q    <= oe_d;
    end
  end

  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign out_data  = od_q;
  assign out_err   = oe_q;
endmodule
